// File: rtl/spc700_muldiv_seq_pkg.sv
// spc700_muldiv_seq_pkg: shared types and secondary-op codes for the SPC700 mul/div sequencer.
//   SECOP_*        : datapath secondary-op encodings
//   muldiv_state_t : sequencer states
//   muldiv_wb_r    : registered write-back packet (YA plus PSW N/Z/V/H and V/H write enable)
package spc700_muldiv_seq_pkg;
  localparam logic [3:0] SECOP_MD_LOAD = 4'b0000;
  localparam logic [3:0] SECOP_MUL     = 4'b1110;
  localparam logic [3:0] SECOP_DIV     = 4'b1111;
  typedef enum logic [2:0] {IDLE, LOAD, MUL_IT, DIV_IT, DIV_RD, WB} muldiv_state_t;
  typedef struct packed {
    logic [15:0] ya;
    logic        n;
    logic        z;
    logic        v;
    logic        h;
    logic        vh_we;
  } muldiv_wb_r;
endpackage

// File: rtl/spc700_muldiv_seq.sv
// spc700_muldiv_seq: sequences MUL YA / DIV YA,X through the mul/div datapath and registers the write-back packet.
//   CLK, RST_N (sync, active-low), CE (clock enable)
//   START, OP (0 = MUL, 1 = DIV)      : request from the micro-sequencer
//   BUSY, DONE                        : status; DONE is a one CE-cycle pulse
//   MD_EN, MD_SECOP                   : datapath control
//   MD_RES, MD_ZO, MD_VO, MD_HO       : datapath result and flags
//   WB_YA, WB_N/Z/V/H, WB_VH_WE       : write-back packet to the register file
module spc700_muldiv_seq
  import spc700_muldiv_seq_pkg::*;
#(
  parameter int MUL_ITER = 8,
  parameter int DIV_ITER = 9
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic        START,
  input  logic        OP,
  output logic        BUSY,
  output logic        DONE,
  output logic        MD_EN,
  output logic [3:0]  MD_SECOP,
  input  logic [15:0] MD_RES,
  input  logic        MD_ZO,
  input  logic        MD_VO,
  input  logic        MD_HO,
  output logic [15:0] WB_YA,
  output logic        WB_N,
  output logic        WB_Z,
  output logic        WB_V,
  output logic        WB_H,
  output logic        WB_VH_WE
);
  localparam int CW = $clog2(MUL_ITER > DIV_ITER ? MUL_ITER : DIV_ITER);
  muldiv_state_t state;
  logic [CW-1:0] cnt;
  logic          op_div;
  logic          busy_r;
  logic          done_r;
  logic          en_r;
  logic [3:0]    secop_r;
  muldiv_wb_r    wb;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      op_div  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      en_r    <= 1'b0;
      secop_r <= SECOP_MD_LOAD;
      wb      <= '0;
    end else if (CE) begin
      case (state)
        IDLE: if (START) begin
          state   <= LOAD;
          op_div  <= OP;
          busy_r  <= 1'b1;
          en_r    <= 1'b1;
          secop_r <= SECOP_MD_LOAD;
        end
        LOAD: begin
          state   <= op_div ? DIV_IT : MUL_IT;
          cnt     <= '0;
          secop_r <= op_div ? SECOP_DIV : SECOP_MUL;
        end
        MUL_IT: begin
          cnt <= cnt + 1'b1;
          // The datapath output already holds the full product during the last step cycle.
          if (cnt == CW'(MUL_ITER - 1)) begin
            state   <= WB;
            en_r    <= 1'b0;
            secop_r <= SECOP_MD_LOAD;
            done_r  <= 1'b1;
            wb      <= '{ya: MD_RES, n: MD_RES[15], z: MD_ZO, v: 1'b0, h: 1'b0, vh_we: 1'b0};
          end
        end
        DIV_IT: begin
          cnt <= cnt + 1'b1;
          // Keep SECOP at div/read but stop stepping so the result settles for one read cycle.
          if (cnt == CW'(DIV_ITER - 1)) begin
            state <= DIV_RD;
            en_r  <= 1'b0;
          end
        end
        DIV_RD: begin
          state   <= WB;
          secop_r <= SECOP_MD_LOAD;
          done_r  <= 1'b1;
          wb      <= '{ya: MD_RES, n: MD_RES[7], z: MD_ZO, v: MD_VO, h: MD_HO, vh_we: 1'b1};
        end
        WB: begin
          state    <= IDLE;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          wb.vh_we <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // The datapath must not step on a disabled cycle, so the enable is gated by CE.
  assign MD_EN    = en_r & CE;
  assign MD_SECOP = secop_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign WB_YA    = wb.ya;
  assign WB_N     = wb.n;
  assign WB_Z     = wb.z;
  assign WB_V     = wb.v;
  assign WB_H     = wb.h;
  assign WB_VH_WE = wb.vh_we;
endmodule

// File: tb/tb_spc700_muldiv_seq.sv
// tb_spc700_muldiv_seq: self-checking bench with a behavioural mul/div datapath and arithmetic reference.
module tb_spc700_muldiv_seq;
  logic        CLK = 1'b0;
  logic        RST_N, CE, START, OP;
  logic        BUSY, DONE, MD_EN;
  logic [3:0]  MD_SECOP;
  logic [15:0] MD_RES;
  logic        MD_ZO, MD_VO, MD_HO;
  logic [15:0] WB_YA;
  logic        WB_N, WB_Z, WB_V, WB_H, WB_VH_WE;
  int nchk = 0;
  int nerr = 0;
  logic [7:0] ty = 8'h0, ta = 8'h0, tx = 8'h0;
  logic       cur_op = 1'b0;
  logic [7:0] dy = 8'h0, da = 8'h0, dx = 8'h0;
  int         msteps = 0, dsteps = 0;
  logic [15:0] jm = 16'h1;
  logic [15:0] mres;
  logic [17:0] dres;

  spc700_muldiv_seq dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START), .OP(OP),
    .BUSY(BUSY), .DONE(DONE), .MD_EN(MD_EN), .MD_SECOP(MD_SECOP),
    .MD_RES(MD_RES), .MD_ZO(MD_ZO), .MD_VO(MD_VO), .MD_HO(MD_HO),
    .WB_YA(WB_YA), .WB_N(WB_N), .WB_Z(WB_Z), .WB_V(WB_V), .WB_H(WB_H), .WB_VH_WE(WB_VH_WE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] ref_mul(input logic [7:0] y, input logic [7:0] a);
    return 16'(int'(y) * int'(a));
  endfunction

  // SPC700 DIV semantics: returns {Y(rem), A(quot), V, H}.
  function automatic logic [17:0] ref_div(input logic [7:0] y, input logic [7:0] a, input logic [7:0] x);
    int ya, xi, q, r;
    logic [7:0] qb, rb;
    ya = int'({y, a});
    xi = int'(x);
    if (int'(y) < 2 * xi) begin
      q = ya / xi;
      r = ya % xi;
    end else begin
      q = 255 - (ya - xi * 512) / (256 - xi);
      r = xi + (ya - xi * 512) % (256 - xi);
    end
    qb = 8'(q);
    rb = 8'(r);
    return {rb, qb, y >= x, y[3:0] >= x[3:0]};
  endfunction

  // Datapath model: loads on SECOP load, counts steps; the result is only correct at the right step count.
  always @(posedge CLK) begin
    jm <= 16'($urandom) | 16'h1;
    if (MD_EN) begin
      if (MD_SECOP == 4'b0000) begin
        dy <= ty; da <= ta; dx <= tx; msteps <= 0; dsteps <= 0;
      end else if (MD_SECOP == 4'b1110) msteps <= msteps + 1;
      else if (MD_SECOP == 4'b1111) dsteps <= dsteps + 1;
    end
  end

  always_comb begin
    mres = ref_mul(dy, da);
    dres = ref_div(dy, da, dx);
    MD_RES = (cur_op ? dres[17:2] : mres) ^ jm;
    MD_ZO  = cur_op ? (dres[9:2] != 8'h0) : (mres[15:8] != 8'h0);
    MD_VO  = cur_op ? ~dres[1] : 1'b1;
    MD_HO  = cur_op ? ~dres[0] : 1'b1;
    if (msteps == 7 && dsteps == 0) begin
      MD_RES = mres;
      MD_ZO  = (mres[15:8] == 8'h0);
    end else if (dsteps == 9 && msteps == 0) begin
      MD_RES = dres[17:2];
      MD_ZO  = (dres[9:2] == 8'h0);
      MD_VO  = dres[1];
      MD_HO  = dres[0];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic op, input logic [7:0] y, input logic [7:0] a, input logic [7:0] x,
                        input logic [15:0] eya, input logic ev, input logic eh, input logic tog, input logic smid);
    int ce_edges = 0;
    int n = 0;
    logic en_bad = 1'b0;
    logic busy_bad = 1'b0;
    logic en, ez;
    ty = y; ta = a; tx = x; cur_op = op;
    OP = op; START = 1'b1; CE = 1'b1;
    tick();
    START = 1'b0;
    chk("busy_after_start", 32'(BUSY), 32'(1'b1));
    while (!DONE && n < 60) begin
      if (tog) CE = ~CE;
      START = smid && n >= 3 && n < 5;
      OP = ~op;
      if (CE) ce_edges++;
      tick();
      n++;
      if (!CE && MD_EN) en_bad = 1'b1;
      if (!BUSY) busy_bad = 1'b1;
    end
    START = 1'b0;
    OP = op;
    chk("done_seen", 32'(DONE), 32'(1'b1));
    chk("latency", 32'(ce_edges + 1), op ? 32'd12 : 32'd10);
    en = op ? eya[7] : eya[15];
    ez = op ? (eya[7:0] == 8'h0) : (eya[15:8] == 8'h0);
    chk("wb_ya", 32'(WB_YA), 32'(eya));
    chk("wb_nzvh", 32'({WB_N, WB_Z, WB_V, WB_H}), 32'({en, ez, ev, eh}));
    chk("wb_vh_we", 32'(WB_VH_WE), 32'(op));
    chk("busy_in_done", 32'(BUSY), 32'(1'b1));
    chk("md_en_while_ce0", 32'(en_bad), 32'(1'b0));
    chk("busy_during_op", 32'(busy_bad), 32'(1'b0));
    CE = 1'b1;
    tick();
    chk("done_pulse_end", 32'({DONE, BUSY, WB_VH_WE}), 32'(3'b000));
    chk("wb_ya_hold", 32'(WB_YA), 32'(eya));
    tick();
    chk("no_queued_op", 32'(BUSY), 32'(1'b0));
  endtask

  initial begin
    logic [17:0] r;
    logic        op, tog;
    logic [7:0]  y, a, x;
    logic        done_bad;
    RST_N = 1'b0; CE = 1'b0; START = 1'b0; OP = 1'b0;
    tick();
    tick();
    chk("rst_ctrl", 32'({BUSY, DONE, MD_EN, WB_VH_WE}), 32'(4'b0000));
    chk("rst_secop", 32'(MD_SECOP), 32'(4'b0000));
    chk("rst_wb", 32'({WB_YA, WB_N, WB_Z, WB_V, WB_H}), 32'(0));
    RST_N = 1'b1; CE = 1'b1;
    tick();
    chk("idle_no_start", 32'(BUSY), 32'(1'b0));
    run_op(1'b0, 8'h12, 8'h34, 8'h00, 16'h03A8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFF, 8'h00, 16'hFE01, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 8'h00, 8'h55, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'h00, 8'h64, 8'h0A, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'h12, 8'h34, 8'h10, 16'h0423, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 8'h00, 8'h64, 8'h0A, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op(1'b0, 8'h12, 8'h34, 8'h00, 16'h03A8, 1'b0, 1'b0, 1'b1, 1'b1);
    // Abort a DIV mid-iteration with reset (CE low to show reset wins).
    ty = 8'h12; ta = 8'h34; tx = 8'h10; cur_op = 1'b1;
    OP = 1'b1; START = 1'b1; CE = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("in_div_busy", 32'({BUSY, MD_EN, MD_SECOP}), 32'(6'b111111));
    RST_N = 1'b0; CE = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("abort_ctrl", 32'({BUSY, DONE, MD_EN}), 32'(3'b000));
    chk("abort_secop", 32'(MD_SECOP), 32'(4'b0000));
    chk("abort_wb", 32'(WB_YA), 32'(0));
    CE = 1'b1;
    done_bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (DONE || BUSY) done_bad = 1'b1;
    end
    chk("abort_no_done", 32'(done_bad), 32'(1'b0));
    run_op(1'b0, 8'h0C, 8'h0B, 8'h00, 16'h0084, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      op = 1'($urandom);
      tog = 1'($urandom);
      y = 8'($urandom);
      a = 8'($urandom);
      x = 8'($urandom);
      if (op) begin
        r = ref_div(y, a, x);
        run_op(1'b1, y, a, x, r[17:2], r[1], r[0], tog, 1'($urandom));
      end else begin
        run_op(1'b0, y, a, x, ref_mul(y, a), 1'b0, 1'b0, tog, 1'($urandom));
      end
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
